// File: rtl/writeback_unit.sv
// writeback_unit: selects result source, extracts/extends load data, drives the
// register-file write port and counts retired instructions.
module writeback_unit #(
  parameter int RETIRE_W = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [4:0]          rd_i,
  input  logic [1:0]          wb_sel_i,
  input  logic [31:0]         alu_result_i,
  input  logic [31:0]         pc_plus4_i,
  input  logic [2:0]          funct3_i,
  input  logic [1:0]          addr_low_i,
  input  logic [31:0]         mem_rdata_i,
  input  logic                mem_rvalid_i,
  output logic                reg_write_enable_o,
  output logic [4:0]          reg_select_d_o,
  output logic [31:0]         reg_data_d_o,
  output logic                load_fault_o,
  output logic [RETIRE_W-1:0] retired_count_o
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t              state_q;
  logic [4:0]          rd_q, sel_q;
  logic [2:0]          f3_q;
  logic [1:0]          alo_q;
  logic                bad_q, we_q, lf_q;
  logic [31:0]         data_q, ext_d;
  logic [RETIRE_W-1:0] ret_q;
  logic [7:0]          byte_d;
  logic [15:0]         half_d;
  logic                bad_d;
  always_comb begin
    byte_d = mem_rdata_i[{alo_q, 3'b000} +: 8];
    half_d = alo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ext_d  = f3_q == 3'b000 ? {{24{byte_d[7]}}, byte_d} :
             f3_q == 3'b001 ? {{16{half_d[15]}}, half_d} :
             f3_q == 3'b100 ? {24'b0, byte_d} :
             f3_q == 3'b101 ? {16'b0, half_d} : mem_rdata_i;
    // fault is decided from the accept-time fields but reported at completion
    bad_d  = (funct3_i inside {3'b011, 3'b110, 3'b111}) ||
             (funct3_i[1:0] == 2'b01 && addr_low_i[0]) ||
             (funct3_i == 3'b010 && addr_low_i != 2'b00);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rd_q    <= '0;
      f3_q    <= '0;
      alo_q   <= '0;
      bad_q   <= 1'b0;
      we_q    <= 1'b0;
      lf_q    <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
      ret_q   <= '0;
    end else begin
      we_q <= 1'b0;
      lf_q <= 1'b0;
      if (state_q == IDLE) begin
        if (valid_i && wb_sel_i == 2'b01) begin
          rd_q    <= rd_i;
          f3_q    <= funct3_i;
          alo_q   <= addr_low_i;
          bad_q   <= bad_d;
          state_q <= WAIT_LOAD;
        end else if (valid_i) begin
          sel_q  <= rd_i;
          data_q <= wb_sel_i == 2'b10 ? pc_plus4_i : alu_result_i;
          we_q   <= wb_sel_i != 2'b11 && rd_i != 5'd0;
          ret_q  <= ret_q + 1'b1;
        end
      end else if (mem_rvalid_i) begin
        state_q <= IDLE;
        if (bad_q) lf_q <= 1'b1;
        else begin
          sel_q  <= rd_q;
          data_q <= ext_d;
          we_q   <= rd_q != 5'd0;
          ret_q  <= ret_q + 1'b1;
        end
      end
    end
  end
  assign ready_o            = state_q == IDLE;
  assign reg_write_enable_o = we_q;
  assign reg_select_d_o     = sel_q;
  assign reg_data_d_o       = data_q;
  assign load_fault_o       = lf_q;
  assign retired_count_o    = ret_q;
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage of the softcore. Accepts completed instructions from execute and selects the result source: ALU, load data, or PC+4.
- Performs RISC-V load byte/halfword extraction and sign/zero extension.
- Drives the register file write port: write enable, destination select and write data.
- Handles multi-cycle loads with a small FSM that stalls execute, and keeps a 64-bit retired-instruction counter.

Parameters:
- RETIRE_W, 64, width of retired-instruction counter

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high
- valid_i  input  1  execute presents a completed instruction
- ready_o  output  1  unit can accept an instruction this cycle
- rd_i  input  5  destination register
- wb_sel_i  input  2  00 ALU, 01 load, 10 PC+4, 11 no writeback (branch/store)
- alu_result_i  input  32  ALU result
- pc_plus4_i  input  32  link value for JAL/JALR
- funct3_i  input  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- addr_low_i  input  2  low bits of load address
- mem_rdata_i  input  32  aligned word from data memory
- mem_rvalid_i  input  1  mem_rdata_i valid this cycle
- reg_write_enable_o  output  1  register file write enable (one-cycle pulse)
- reg_select_d_o  output  5  register file destination select
- reg_data_d_o  output  32  register file write data
- load_fault_o  output  1  one-cycle pulse on misaligned or illegal load
- retired_count_o  output  RETIRE_W  instructions retired

Behaviour:
Reset:
- All outputs are registered; reset values are 0.
- FSM returns to IDLE, ready_o=1 in the cycle after reset.

Handshake:
- An instruction is accepted when valid_i && ready_o at a rising edge.
- ready_o = 1 only in IDLE.

Non-load accept (wb_sel 00/10/11):
- On the next edge, reg_select_d_o=rd_i and reg_data_d_o=alu_result_i or pc_plus4_i.
- reg_write_enable_o=1 for that single cycle iff wb_sel != 11 and rd_i != 0.
- retired_count_o increments by 1.
- Back-to-back accepts at one per cycle are supported.

Load accept (wb_sel 01):
- Latch rd, funct3 and addr_low.
- Enter WAIT_LOAD; ready_o=0.
- mem_rdata_i/mem_rvalid_i present in the accept cycle itself are ignored.

WAIT_LOAD:
- On the first cycle with mem_rvalid_i=1, extract the data on that edge.
- The next cycle carries reg_write_enable_o=1 (if rd != 0), the data, and retired_count_o+1.
- The FSM returns to IDLE on the same edge, so ready_o=1 in that output cycle.

Extraction:
- LB/LBU take byte mem_rdata_i[8*addr_low +: 8].
- LH/LHU take half mem_rdata_i[16*addr_low[1] +: 16].
- LB/LH sign-extend from the top bit; LBU/LHU zero-extend.
- LW passes the word through.

Faults:
- Conditions: LH/LHU with addr_low[0]=1, LW with addr_low != 0, or funct3 in {011,110,111}.
- On mem_rvalid_i: load_fault_o=1 for one cycle, no write, no retire increment, return to IDLE.
- The fault is detected at accept but reported only on completion, so memory handshakes still close.

Other rules:
- mem_rvalid_i in IDLE is ignored.
- rd=0 writes are suppressed, but the instruction still retires.
- retired_count_o wraps modulo 2^RETIRE_W.
- Reset mid-WAIT_LOAD abandons the load with no write; a later stray mem_rvalid_i is ignored.
- Outputs hold last data between pulses; only the enable and fault flags are pulses.
- Register-file timing: its write occurs at the edge ending the pulse cycle, and the value is readable the following cycle.

Test Plan:
1. Reset, then accept ALU instr rd=5, alu_result_i=0xDEADBEEF -> next cycle we=1, sel=5, data=0xDEADBEEF; retired=1; we=0 after.
2. Three back-to-back accepts: ALU rd=1 0x11, PC+4 rd=2 0x104, wb_sel=11 rd=3 -> pulses on cycles 1,2 (data 0x11, 0x104), no write cycle 3; retired=3; ready_o held 1.
3. LB addr_low=3, mem_rdata_i=0x80FF_0000 after 2-cycle delay -> ready_o=0 until completion; data=0xFFFFFF80 one cycle after rvalid. Same with LBU -> 0x00000080. LHU addr_low=2 -> 0x000080FF. LH -> 0xFFFF80FF.
4. LW addr_low=1, rvalid after 1 cycle -> load_fault_o pulse, we=0, retired unchanged, ready_o=1 same cycle. funct3=011 -> identical fault.
5. ALU rd=0 data 0x1234 -> we=0, retired increments. Stray mem_rvalid_i in IDLE -> no outputs change.
6. Load accepted, rst_i asserted before rvalid, then rvalid after reset -> no write, retired=0, ready_o=1. Preloaded counter 0xFFFF_FFFF_FFFF_FFFF plus one retire -> retired wraps to 0.
